// File: rtl/pe_out_drain_arb.sv
// Drain scheduler for the systolic array's per-row output FIFOs.
// Round-robin pops 4-element words into one registered, row-tagged valid/ready stream.
module pe_out_drain_arb #(
  parameter int NFIFO = 4,
  parameter int WIDTH = 4,
  parameter int WPT   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NFIFO-1:0]             fif_val,
  input  logic [NFIFO*4*WIDTH-1:0]     fif_dout,
  output logic [NFIFO-1:0]             fif_pop,
  output logic [4*WIDTH-1:0]           out_dat,
  output logic [$clog2(NFIFO)-1:0]     out_id,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic                         busy,
  output logic                         done
);

  localparam int DW  = 4 * WIDTH;
  localparam int IDW = $clog2(NFIFO);
  localparam int CW  = $clog2(WPT + 1);
  localparam logic [NFIFO-1:0] POP_ONE = NFIFO'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt [NFIFO];
  logic [IDW-1:0]   rr_ptr;

  logic             free;
  logic [NFIFO-1:0] eligible;
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic             do_grant;
  logic             last_pop;
  logic [DW-1:0]    grant_dat;

  assign free = !out_val || out_rdy;

  // Scan downward from the far end so the entry closest to rr_ptr wins.
  always_comb begin
    int idx;
    eligible  = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int r = 0; r < NFIFO; r++) begin
      eligible[r] = fif_val[r] && (cnt[r] != '0);
    end
    for (int k = NFIFO - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NFIFO;
      if (eligible[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign do_grant  = (state == DRAIN) && free && grant_vld;
  assign fif_pop   = do_grant ? (POP_ONE << grant_id) : '0;
  assign grant_dat = fif_dout[int'(grant_id)*DW +: DW];

  // The tile ends on the pop that takes the only remaining word.
  always_comb begin
    last_pop = do_grant;
    for (int r = 0; r < NFIFO; r++) begin
      if (IDW'(r) == grant_id) begin
        if (cnt[r] > CW'(1)) last_pop = 1'b0;
      end else if (cnt[r] != '0) begin
        last_pop = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_val <= 1'b0;
      out_dat <= '0;
      out_id  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rr_ptr  <= '0;
      for (int r = 0; r < NFIFO; r++) cnt[r] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished tile.
          if (start && !done) begin
            state <= DRAIN;
            busy  <= 1'b1;
            for (int r = 0; r < NFIFO; r++) cnt[r] <= CW'(WPT);
          end
        end
        DRAIN: begin
          if (last_pop) state <= FLUSH;
        end
        FLUSH: begin
          if (out_val && out_rdy) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (do_grant) begin
        out_dat       <= grant_dat;
        out_id        <= grant_id;
        out_val       <= 1'b1;
        cnt[grant_id] <= cnt[grant_id] - CW'(1);
        rr_ptr        <= (grant_id == IDW'(NFIFO - 1)) ? '0 : grant_id + IDW'(1);
      end else if (out_rdy) begin
        out_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_out_drain_arb.sv
// Randomised and directed bench for pe_out_drain_arb against a queue-based row-FIFO
// and tile-level reference model.
module tb_pe_out_drain_arb;
  localparam int NFIFO = 4;
  localparam int WIDTH = 4;
  localparam int WPT   = 2;
  localparam int DW    = 4 * WIDTH;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     out_rdy = 1'b0;
  logic [NFIFO-1:0]         fif_val = '0;
  logic [NFIFO*DW-1:0]      fif_dout = '0;
  logic [NFIFO-1:0]         fif_pop;
  logic [DW-1:0]            out_dat;
  logic [1:0]               out_id;
  logic                     out_val;
  logic                     busy;
  logic                     done;

  pe_out_drain_arb #(.NFIFO(NFIFO), .WIDTH(WIDTH), .WPT(WPT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fif_val(fif_val), .fif_dout(fif_dout),
    .fif_pop(fif_pop), .out_dat(out_dat), .out_id(out_id), .out_val(out_val),
    .out_rdy(out_rdy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rowq [NFIFO][$];
  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: 0 idle, 1 draining, 2 waiting for last word to leave.
  int            m_phase;
  int            m_left [NFIFO];
  int            m_next;
  bit            m_oval;
  logic [DW-1:0] m_odat;
  int            m_oid;
  bit            m_busy;
  bit            m_done;
  int            popped [NFIFO];
  int            delivered [NFIFO];
  int            done_seen;
  int            seq [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void drive_rows();
    for (int r = 0; r < NFIFO; r++) begin
      fif_val[r] = rowq[r].size() > 0;
      fif_dout[r*DW +: DW] = (rowq[r].size() > 0) ? rowq[r][0] : '0;
    end
  endfunction

  function automatic void model_clear();
    m_phase = 0; m_next = 0; m_oval = 0; m_odat = '0; m_oid = 0; m_busy = 0; m_done = 0;
    for (int r = 0; r < NFIFO; r++) begin
      m_left[r] = 0; popped[r] = 0; delivered[r] = 0;
      rowq[r].delete();
    end
  endfunction

  task automatic push_row(input int r, input int n);
    for (int i = 0; i < n; i++) rowq[r].push_back(DW'($urandom));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_eq("rst_out_val", 32'(out_val), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_out_id", 32'(out_id), 0);
    check_eq("rst_out_dat", 32'(out_dat), 0);
    model_clear();
    drive_rows();
    #1;
    check_eq("rst_fif_pop", 32'(fif_pop), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check pop combinationally, advance model at posedge,
  // check registered outputs at the following negedge.
  task automatic cycle(input bit st, input bit rdy);
    int gr, r, total, old_oid, nd;
    bit acc;
    start = st;
    out_rdy = rdy;
    drive_rows();
    #1;
    gr = -1;
    if (m_phase == 1 && (!m_oval || rdy)) begin
      for (int k = 0; k < NFIFO; k++) begin
        r = (m_next + k) % NFIFO;
        if (gr < 0 && rowq[r].size() > 0 && m_left[r] > 0) gr = r;
      end
    end
    check_eq("fif_pop", 32'(fif_pop), (gr >= 0) ? (32'd1 << gr) : 32'd0);
    check_eq("pop_onehot", 32'($countones(fif_pop) <= 1), 1);
    check_eq("pop_without_val", 32'(fif_pop & ~fif_val), 0);
    @(posedge clk);
    total = 0;
    for (int i = 0; i < NFIFO; i++) total += m_left[i];
    acc = m_oval && rdy;
    old_oid = m_oid;
    nd = 0;
    if (acc) delivered[old_oid]++;
    if (m_phase == 0) begin
      if (st && !m_done) begin
        m_phase = 1; m_busy = 1;
        for (int i = 0; i < NFIFO; i++) m_left[i] = WPT;
      end
    end else if (m_phase == 1) begin
      if (gr >= 0 && total == 1) m_phase = 2;
    end else if (acc) begin
      m_phase = 0; m_busy = 0; nd = 1;
    end
    if (gr >= 0) begin
      m_odat = rowq[gr].pop_front();
      m_oid = gr; m_oval = 1;
      m_left[gr]--;
      m_next = (gr + 1) % NFIFO;
      popped[gr]++;
    end else if (rdy) begin
      m_oval = 0;
    end
    m_done = (nd != 0);
    @(negedge clk);
    start = 1'b0;
    check_eq("out_val", 32'(out_val), 32'(m_oval));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    if (m_oval) begin
      check_eq("out_id", 32'(out_id), 32'(m_oid));
      check_eq("out_dat", 32'(out_dat), 32'(m_odat));
    end
    if (done) done_seen++;
    if (out_val) seq.push_back(int'(out_id));
  endtask

  initial begin
    logic [DW-1:0] held_dat;
    logic [1:0]    held_id;
    int            waited;

    model_clear();
    @(negedge clk);
    apply_reset();

    // Test 1: all rows ready, no backpressure -> 0,1,2,3,0,1,2,3 then done.
    for (int r = 0; r < NFIFO; r++) push_row(r, 3);
    seq.delete(); done_seen = 0;
    cycle(1, 1);
    for (int i = 0; i < 11; i++) cycle(0, 1);
    check_eq("t1_words", 32'(seq.size()), 8);
    for (int i = 0; i < 8 && i < seq.size(); i++) check_eq("t1_order", 32'(seq[i]), 32'(i % 4));
    check_eq("t1_done_pulses", 32'(done_seen), 1);

    // Test 2: only row 2 has data; later the other rows arrive.
    apply_reset();
    push_row(2, 3);
    cycle(1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1);
    check_eq("t2_row2_pops", 32'(popped[2]), 2);
    check_eq("t2_still_busy", 32'(busy), 1);
    push_row(0, 2); push_row(1, 2); push_row(3, 2);
    seq.delete(); done_seen = 0;
    for (int i = 0; i < 10; i++) cycle(0, 1);
    check_eq("t2_words", 32'(seq.size()), 6);
    if (seq.size() > 0) check_eq("t2_first_id", 32'(seq[0]), 3);
    check_eq("t2_done_pulses", 32'(done_seen), 1);

    // Test 3: five cycles of backpressure mid-tile.
    apply_reset();
    for (int r = 0; r < NFIFO; r++) push_row(r, 2);
    done_seen = 0;
    cycle(1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1);
    held_dat = out_dat;
    held_id = out_id;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0);
      check_eq("t3_dat_hold", 32'(out_dat), 32'(held_dat));
      check_eq("t3_id_hold", 32'(out_id), 32'(held_id));
    end
    for (int i = 0; i < 10; i++) cycle(0, 1);
    for (int r = 0; r < NFIFO; r++) check_eq("t3_delivered", 32'(delivered[r]), 2);
    check_eq("t3_done_pulses", 32'(done_seen), 1);

    // Test 4: start while busy and in the done cycle are ignored.
    apply_reset();
    for (int r = 0; r < NFIFO; r++) push_row(r, 4);
    cycle(1, 1);
    cycle(0, 1);
    cycle(1, 1);
    waited = 0;
    while (!done && waited < 40) begin cycle(0, 1); waited++; end
    check_eq("t4_first_done", 32'(done), 1);
    cycle(1, 1);
    check_eq("t4_start_in_done_ignored", 32'(busy), 0);
    cycle(1, 1);
    check_eq("t4_restart_busy", 32'(busy), 1);
    waited = 0;
    while (!done && waited < 40) begin cycle(0, 1); waited++; end
    check_eq("t4_second_done", 32'(done), 1);
    for (int r = 0; r < NFIFO; r++) check_eq("t4_pops", 32'(popped[r]), 4);

    // Test 5: asynchronous reset between edges mid-drain.
    apply_reset();
    for (int r = 0; r < NFIFO; r++) push_row(r, 2);
    cycle(1, 1);
    for (int i = 0; i < 2; i++) cycle(0, 1);
    out_rdy = 1'b1;
    drive_rows();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_out_val", 32'(out_val), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_fif_pop", 32'(fif_pop), 0);
    model_clear();
    drive_rows();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NFIFO; r++) push_row(r, 2);
    cycle(1, 1);
    cycle(0, 1);
    check_eq("t5_rr_restart", 32'(out_id), 0);
    for (int i = 0; i < 10; i++) cycle(0, 1);

    // Random traffic: sporadic row fills, random backpressure and start pulses.
    apply_reset();
    for (int n = 0; n < 2500; n++) begin
      for (int r = 0; r < NFIFO; r++)
        if ($urandom_range(2) == 0 && rowq[r].size() < 6) push_row(r, 1);
      cycle($urandom_range(7) == 0, $urandom_range(3) != 0);
    end
    waited = 0;
    while (!(m_phase == 0 && !m_oval) && waited < 200) begin
      for (int r = 0; r < NFIFO; r++) if (rowq[r].size() == 0) push_row(r, 1);
      cycle(0, 1);
      waited++;
    end
    check_eq("rand_drained", 32'(m_phase == 0 && !m_oval), 1);
    for (int r = 0; r < NFIFO; r++) check_eq("rand_pop_vs_deliver", 32'(delivered[r]), 32'(popped[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
